// File: rtl/mux_n_arb_pipe_pkg.sv
// Shared definitions for the N-channel registered bus mux and its arbiters:
// mode encoding and a constant-evaluable ceil(log2) helper.
package mux_n_arb_pipe_pkg;

    typedef enum logic {
        MUX_MODE_FIXED = 1'b0,
        MUX_MODE_RR    = 1'b1
    } mux_mode_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned w = 1; w < n; w = w << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_n_arb_pipe_rr_arbiter_n.sv
// Combinational rotating-priority arbiter: picks the first valid requester
// starting at the pointer and wrapping modulo N.
module rr_arbiter_n #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] index_o,
    output logic          any_valid_o
);

    int unsigned pos;

    always_comb begin
        grant_o     = '0;
        index_o     = '0;
        any_valid_o = 1'b0;
        pos         = 0;
        for (int unsigned off = 0; off < N; off++) begin
            // ptr_i is always < N, so one conditional subtract replaces the modulo
            pos = int'(ptr_i) + off;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!any_valid_o && valid_i[IW'(pos)]) begin
                any_valid_o = 1'b1;
                index_o     = IW'(pos);
            end
        end
        if (any_valid_o) begin
            grant_o[index_o] = 1'b1;
        end
    end

endmodule

// File: rtl/mux_n_arb_pipe.sv
// N-channel registered bus mux with valid/ready handshake; channel chosen by
// an external select (FIXED) or a round-robin arbiter (RR).
module mux_n_arb_pipe
    import mux_n_arb_pipe_pkg::*;
#(
    parameter int unsigned DATAWIDTH_BUS           = 32,
    parameter int unsigned NUM_CHANNELS            = 4,
    parameter int unsigned DATAWIDTH_MUX_SELECTION = 2
) (
    input  logic                                    CC_MUX_CLOCK_50,
    input  logic                                    CC_MUX_RESET_InHigh,
    input  logic [NUM_CHANNELS*DATAWIDTH_BUS-1:0]   CC_MUX_data_InBUS,
    input  logic [NUM_CHANNELS-1:0]                 CC_MUX_valid_InBUS,
    output logic [NUM_CHANNELS-1:0]                 CC_MUX_ready_OutBUS,
    input  logic                                    CC_MUX_mode_In,
    input  logic [DATAWIDTH_MUX_SELECTION-1:0]      CC_MUX_selection_InBUS,
    output logic [DATAWIDTH_BUS-1:0]                CC_MUX_data_OutBUS,
    output logic                                    CC_MUX_valid_Out,
    input  logic                                    CC_MUX_ready_In,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]      CC_MUX_grant_OutBUS
);

    localparam int unsigned DW       = DATAWIDTH_BUS;
    localparam int unsigned SW       = DATAWIDTH_MUX_SELECTION;
    localparam int unsigned SEL_SPAN = 1 << SW;
    // Bit s set when select value s names a real channel
    localparam logic [SEL_SPAN-1:0] CHAN_MASK = SEL_SPAN'((64'd1 << NUM_CHANNELS) - 64'd1);

    if (SW != clog2(NUM_CHANNELS) || NUM_CHANNELS < 2 || NUM_CHANNELS > 16) begin : g_bad_params
        $error("mux_n_arb_pipe: NUM_CHANNELS must be 2..16 and DATAWIDTH_MUX_SELECTION = clog2(NUM_CHANNELS)");
    end

    logic [DW-1:0]           data_q, data_d;
    logic                    valid_q, valid_d;
    logic [SW-1:0]           grant_q, grant_d;
    logic [SW-1:0]           ptr_q, ptr_d;

    logic [NUM_CHANNELS-1:0] arb_grant;
    logic [SW-1:0]           arb_index;
    logic                    arb_any;

    logic                    rr_mode;
    logic                    free;
    logic                    cand_exists;
    logic [SW-1:0]           cand_idx;
    logic                    cand_valid;
    logic [DW-1:0]           cand_data;
    logic                    load;

    rr_arbiter_n #(
        .N  (NUM_CHANNELS),
        .IW (SW)
    ) u_rr_arbiter (
        .valid_i     (CC_MUX_valid_InBUS),
        .ptr_i       (ptr_q),
        .grant_o     (arb_grant),
        .index_o     (arb_index),
        .any_valid_o (arb_any)
    );

    always_comb begin
        rr_mode    = (mux_mode_e'(CC_MUX_mode_In) == MUX_MODE_RR);
        free       = !valid_q || CC_MUX_ready_In;
        cand_valid = 1'b0;
        cand_data  = '0;
        CC_MUX_ready_OutBUS = '0;

        if (rr_mode) begin
            cand_exists = arb_any;
            cand_idx    = arb_index;
        end else begin
            cand_exists = CHAN_MASK[CC_MUX_selection_InBUS];
            cand_idx    = CC_MUX_selection_InBUS;
        end

        for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
            if (cand_idx == SW'(k)) begin
                cand_valid = CC_MUX_valid_InBUS[k];
                cand_data  = CC_MUX_data_InBUS[k*DW +: DW];
                CC_MUX_ready_OutBUS[k] = cand_exists && free && !CC_MUX_RESET_InHigh;
            end
        end

        load = free && cand_exists && cand_valid;

        valid_d = load ? 1'b1 : (free ? 1'b0 : valid_q);
        data_d  = load ? cand_data : data_q;
        grant_d = load ? cand_idx : grant_q;
        ptr_d   = ptr_q;
        if (load && rr_mode) begin
            ptr_d = (cand_idx == SW'(NUM_CHANNELS - 1)) ? '0 : cand_idx + 1'b1;
        end
    end

    always_ff @(posedge CC_MUX_CLOCK_50 or posedge CC_MUX_RESET_InHigh) begin
        if (CC_MUX_RESET_InHigh) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign CC_MUX_data_OutBUS  = data_q;
    assign CC_MUX_valid_Out    = valid_q;
    assign CC_MUX_grant_OutBUS = grant_q;

endmodule

// File: tb/tb_mux_n_arb_pipe.sv
// Self-checking bench for mux_n_arb_pipe: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_mux_n_arb_pipe;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic [N*DW-1:0] din;
    logic [N-1:0]    vin;
    logic [N-1:0]    rdy;
    logic            mode;
    logic [1:0]      sel;
    logic [DW-1:0]   dout;
    logic            vout;
    logic            rin;
    logic [1:0]      gnt;

    logic [3*DW-1:0] din3;
    logic [2:0]      vin3;
    logic [2:0]      rdy3;
    logic            mode3;
    logic [1:0]      sel3;
    logic [DW-1:0]   dout3;
    logic            vout3;
    logic            rin3;
    logic [1:0]      gnt3;

    int checks;
    int errors;

    mux_n_arb_pipe #(
        .DATAWIDTH_BUS           (DW),
        .NUM_CHANNELS            (N),
        .DATAWIDTH_MUX_SELECTION (2)
    ) dut (
        .CC_MUX_CLOCK_50        (clk),
        .CC_MUX_RESET_InHigh    (rst),
        .CC_MUX_data_InBUS      (din),
        .CC_MUX_valid_InBUS     (vin),
        .CC_MUX_ready_OutBUS    (rdy),
        .CC_MUX_mode_In         (mode),
        .CC_MUX_selection_InBUS (sel),
        .CC_MUX_data_OutBUS     (dout),
        .CC_MUX_valid_Out       (vout),
        .CC_MUX_ready_In        (rin),
        .CC_MUX_grant_OutBUS    (gnt)
    );

    mux_n_arb_pipe #(
        .DATAWIDTH_BUS           (DW),
        .NUM_CHANNELS            (3),
        .DATAWIDTH_MUX_SELECTION (2)
    ) dut3 (
        .CC_MUX_CLOCK_50        (clk),
        .CC_MUX_RESET_InHigh    (rst),
        .CC_MUX_data_InBUS      (din3),
        .CC_MUX_valid_InBUS     (vin3),
        .CC_MUX_ready_OutBUS    (rdy3),
        .CC_MUX_mode_In         (mode3),
        .CC_MUX_selection_InBUS (sel3),
        .CC_MUX_data_OutBUS     (dout3),
        .CC_MUX_valid_Out       (vout3),
        .CC_MUX_ready_In        (rin3),
        .CC_MUX_grant_OutBUS    (gnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic       rin;
        logic [3:0] exp_ready;
        logic       exp_vout;
        logic [1:0] exp_grant;
    } vec_t;

    vec_t tbl [18];

    // behavioural model state
    bit       m_valid;
    bit [31:0] m_data;
    int       m_grant;
    int       m_ptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_valid = 0; m_data = 0; m_grant = 0; m_ptr = 0;
    endtask

    task automatic tagged_data();
        for (int k = 0; k < N; k++) din[k*DW +: DW] = 32'hA5A5_0000 | k;
    endtask

    // returns expected ready vector and updates model on the coming edge
    task automatic model_step(output logic [3:0] exp_rdy);
        bit found, exists, free, load;
        int c;
        found = 0; c = 0;
        if (mode) begin
            for (int off = 0; off < N; off++) begin
                int k;
                k = (m_ptr + off) % N;
                if (!found && vin[k]) begin found = 1; c = k; end
            end
            exists = found;
        end else begin
            c = int'(sel);
            exists = (c < N);
        end
        free = !m_valid || rin;
        exp_rdy = (exists && free) ? 4'(1 << c) : 4'b0000;
        load = free && exists && vin[c];
        if (load) begin
            m_valid = 1;
            m_data  = din[c*DW +: DW];
            m_grant = c;
            if (mode) m_ptr = (c + 1) % N;
        end else if (free) begin
            m_valid = 0;
        end
    endtask

    initial begin
        logic [3:0] er;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        din = '0; vin = '0; mode = 1'b0; sel = '0; rin = 1'b1;
        din3 = '0; vin3 = '0; mode3 = 1'b0; sel3 = '0; rin3 = 1'b1;

        // --- reset with all channels requesting
        tagged_data();
        vin  = 4'b1111;
        mode = 1'b1;
        tick();
        tick();
        chk("rst_vout", 32'(vout), 32'd0);
        chk("rst_data", dout, 32'd0);
        chk("rst_grant", 32'(gnt), 32'd0);
        chk("rst_ready", 32'(rdy), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_ready", 32'(rdy), 32'b0001);
        tick();
        chk("rel_vout", 32'(vout), 32'd1);
        chk("rel_grant", 32'(gnt), 32'd0);
        chk("rel_data", dout, 32'hA5A5_0000);

        // --- directed table
        tbl[0]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[1]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[2]  = '{1'b0, 2'd1, 4'b0100, 1'b1, 4'b0010, 1'b0, 2'd2};
        tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[8]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[9]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[10] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[11] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[12] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[13] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[14] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[15] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3};
        tbl[16] = '{1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[17] = '{1'b0, 2'd3, 4'b1000, 1'b0, 4'b0000, 1'b1, 2'd3};

        do_reset();
        tagged_data();
        for (int i = 0; i < 18; i++) begin
            mode = tbl[i].mode;
            sel  = tbl[i].sel;
            vin  = tbl[i].valid;
            rin  = tbl[i].rin;
            #1;
            chk($sformatf("tbl%0d_ready", i), 32'(rdy), 32'(tbl[i].exp_ready));
            tick();
            chk($sformatf("tbl%0d_vout", i), 32'(vout), 32'(tbl[i].exp_vout));
            chk($sformatf("tbl%0d_grant", i), 32'(gnt), 32'(tbl[i].exp_grant));
            chk($sformatf("tbl%0d_data", i), dout, 32'hA5A5_0000 | 32'(tbl[i].exp_grant));
        end

        // --- backpressure: output frozen, then pop and load in one cycle
        do_reset();
        mode = 1'b0; sel = 2'd0; vin = 4'b0001; rin = 1'b1;
        din[0 +: DW] = 32'h1111_AAAA;
        tick();
        rin = 1'b0; sel = 2'd1; vin = 4'b1111;
        din[0 +: DW] = 32'h2222_BBBB;
        din[DW +: DW] = 32'h3333_CCCC;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", 32'(rdy), 32'd0);
            tick();
            chk("bp_vout", 32'(vout), 32'd1);
            chk("bp_data", dout, 32'h1111_AAAA);
            chk("bp_grant", 32'(gnt), 32'd0);
        end
        rin = 1'b1;
        #1;
        chk("bp_release_ready", 32'(rdy), 32'b0010);
        tick();
        chk("bp_reload_vout", 32'(vout), 32'd1);
        chk("bp_reload_data", dout, 32'h3333_CCCC);
        chk("bp_reload_grant", 32'(gnt), 32'd1);

        // --- reset mid-stream
        do_reset();
        tagged_data();
        mode = 1'b1; vin = 4'b1111; rin = 1'b1;
        tick(); tick(); tick();
        chk("ms_pre_grant", 32'(gnt), 32'd2);
        rst = 1'b1;
        #1;
        chk("ms_async_vout", 32'(vout), 32'd0);
        chk("ms_async_ready", 32'(rdy), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("ms_rel_ready", 32'(rdy), 32'b0001);
        tick();
        chk("ms_first_grant", 32'(gnt), 32'd0);
        chk("ms_first_vout", 32'(vout), 32'd1);

        // --- out-of-range select on a 3-channel instance
        for (int k = 0; k < 3; k++) din3[k*DW +: DW] = 32'hC0DE_0000 | k;
        mode3 = 1'b0; sel3 = 2'd3; vin3 = 3'b111; rin3 = 1'b1;
        #1;
        chk("oor_ready", 32'(rdy3), 32'd0);
        tick();
        tick();
        chk("oor_vout", 32'(vout3), 32'd0);
        sel3 = 2'd2;
        #1;
        chk("n3_ready", 32'(rdy3), 32'b100);
        tick();
        chk("n3_vout", 32'(vout3), 32'd1);
        chk("n3_data", dout3, 32'hC0DE_0002);

        // --- randomized run against the model
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            mode = 1'($urandom_range(0, 1));
            sel  = 2'($urandom_range(0, 3));
            vin  = 4'($urandom);
            rin  = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) din[k*DW +: DW] = $urandom;
            #1;
            model_step(er);
            chk("rnd_ready", 32'(rdy), 32'(er));
            tick();
            chk("rnd_vout", 32'(vout), 32'(m_valid));
            chk("rnd_grant", 32'(gnt), 32'(m_grant));
            chk("rnd_data", dout, m_data);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
